// File: rtl/result_sender.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : result_sender
//  Purpose  : Serialises one 38-byte result frame to a byte-wide UART
//             transmitter. The frame is made up of a sync byte, 32 hash bytes
//             and 4 nonce bytes, each sent LSB-byte first, followed by an XOR
//             checksum of bytes 1..36. Every byte has its own tx_done timeout.
//  Ports    : clk             - system clock, rising edge
//             rst_i           - asynchronous active-low reset
//             start           - one-cycle frame request (honoured only in IDLE)
//             best_hash       - 256-bit hash, captured when the frame starts
//             best_hash_nonce - 32-bit nonce, captured when the frame starts
//             tx_active       - transmitter busy; holds off the byte strobe
//             tx_done         - transmitter byte-complete strobe
//             tx_dv           - byte-valid strobe to the transmitter
//             tx_byte         - byte presented to the transmitter
//             busy            - high while a frame is being handled
//             done            - one-cycle pulse after the last byte
//             error           - one-cycle pulse on a per-byte timeout abort
//             byte_index      - index of the byte in flight, 0..37
//  Revision : 1.0 - initial release
// ============================================================================
module result_sender #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         start,
  input  logic [255:0] best_hash,
  input  logic [31:0]  best_hash_nonce,
  input  logic         tx_active,
  input  logic         tx_done,
  output logic         tx_dv,
  output logic [7:0]   tx_byte,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [5:0]   byte_index
);

  localparam logic [5:0] c_LAST_IDX = 6'd37;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEND  = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  state_t         state_q;
  logic [255:0]   hash_q;
  logic [31:0]    nonce_q;
  logic [7:0]     chk_q;
  logic [7:0]     tx_byte_q;
  logic [5:0]     idx_q;
  logic [31:0]    tout_q;
  logic           busy_q;
  logic           done_q;
  logic           error_q;

  logic [5:0]     next_idx_d;
  logic [7:0]     next_byte_d;
  logic [31:0]    tout_inc_d;

  // The byte for index idx_q+1 is hash byte idx_q (for 1..32) or nonce byte
  // idx_q-32 (for 33..36), so the current index doubles as the byte selector.
  // For index 37 the running checksum already contains byte 36.
  always_comb begin
    next_idx_d = idx_q + 6'd1;
    tout_inc_d = tout_q + 32'd1;
    if (next_idx_d <= 6'd32) begin
      next_byte_d = hash_q[{idx_q[4:0], 3'b000} +: 8];
    end else if (next_idx_d <= 6'd36) begin
      next_byte_d = nonce_q[{idx_q[1:0], 3'b000} +: 8];
    end else begin
      next_byte_d = chk_q;
    end
  end

  // The strobe reacts to tx_active in the same cycle so that it fires on the
  // very cycle the transmitter frees up; it also drops as soon as the state
  // register is reset.
  assign tx_dv      = (state_q == S_SEND) && !tx_active;
  assign tx_byte    = tx_byte_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign byte_index = idx_q;

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      hash_q    <= '0;
      nonce_q   <= '0;
      chk_q     <= '0;
      tx_byte_q <= '0;
      idx_q     <= '0;
      tout_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            hash_q    <= best_hash;
            nonce_q   <= best_hash_nonce;
            chk_q     <= '0;
            idx_q     <= '0;
            tout_q    <= '0;
            tx_byte_q <= SYNC_BYTE;
            busy_q    <= 1'b1;
            state_q   <= S_SEND;
          end
        end

        S_SEND: begin
          if (!tx_active) begin
            // Sync byte and the checksum itself stay out of the checksum.
            if ((idx_q != 6'd0) && (idx_q != c_LAST_IDX)) begin
              chk_q <= chk_q ^ tx_byte_q;
            end
            tout_q  <= '0;
            state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (tx_done) begin
            if (idx_q == c_LAST_IDX) begin
              idx_q   <= '0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q     <= next_idx_d;
              tx_byte_q <= next_byte_d;
              state_q   <= S_SEND;
            end
          end else if (tout_inc_d >= TIMEOUT_CYCLES) begin
            idx_q   <= '0;
            error_q <= 1'b1;
            state_q <= S_ABORT;
          end else begin
            tout_q <= tout_inc_d;
          end
        end

        S_DONE, S_ABORT: begin
          done_q    <= 1'b0;
          error_q   <= 1'b0;
          busy_q    <= 1'b0;
          tx_byte_q <= '0;
          state_q   <= S_IDLE;
        end

        default: begin
          done_q    <= 1'b0;
          error_q   <= 1'b0;
          busy_q    <= 1'b0;
          idx_q     <= '0;
          tx_byte_q <= '0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_result_sender.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_result_sender
//  Purpose  : Self-checking bench for result_sender. A responder models the
//             UART (tx_done 10 cycles after each tx_dv, optional tx_active
//             stall, optional silence for timeouts); a queue holds the
//             expected (index, byte) pairs of every frame that was started.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_result_sender;

  localparam logic [7:0] c_SYNC = 8'hA5;

  logic         clk;
  logic         rst_i;
  logic         start;
  logic [255:0] best_hash;
  logic [31:0]  best_hash_nonce;
  logic         tx_active;
  logic         tx_done;
  logic         tx_dv;
  logic [7:0]   tx_byte;
  logic         busy;
  logic         done;
  logic         error;
  logic [5:0]   byte_index;

  result_sender #(
    .SYNC_BYTE      (c_SYNC),
    .TIMEOUT_CYCLES (32'd50)
  ) u_dut (
    .clk             (clk),
    .rst_i           (rst_i),
    .start           (start),
    .best_hash       (best_hash),
    .best_hash_nonce (best_hash_nonce),
    .tx_active       (tx_active),
    .tx_done         (tx_done),
    .tx_dv           (tx_dv),
    .tx_byte         (tx_byte),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .byte_index      (byte_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] idx;
    logic [7:0] b;
  } exp_t;

  exp_t sb_q[$];
  exp_t e_mon;

  int n_checks;
  int n_fail;
  int cyc, dv_count, done_count, err_count;
  int resp_cnt, act_cnt, done_cyc, err_cyc, abort_cyc, last_idx;
  bit stall_en, abort_en;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [255:0] h, input logic [31:0] n);
    logic [7:0] x;
    x = 8'h00;
    sb_q.push_back({6'd0, c_SYNC});
    for (int k = 0; k < 32; k++) begin
      sb_q.push_back({6'(k + 1), h[8*k +: 8]});
      x ^= h[8*k +: 8];
    end
    for (int k = 0; k < 4; k++) begin
      sb_q.push_back({6'(33 + k), n[8*k +: 8]});
      x ^= n[8*k +: 8];
    end
    sb_q.push_back({6'd37, x});
  endtask

  // UART model (drives at the falling edge) and output monitor (samples 1 ns
  // later, so it sees what the DUT will commit at the next rising edge).
  always @(negedge clk) begin
    cyc++;
    tx_done = 1'b0;
    if (act_cnt > 0) act_cnt--;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        tx_done  = 1'b1;
        done_cyc = cyc;
        if (stall_en && last_idx == 4) act_cnt = 4;
      end
    end
    tx_active = (act_cnt > 0);
    #1;
    if (tx_dv) begin
      dv_count++;
      if (sb_q.size() == 0) begin
        check_val("unexpected_strobe", {byte_index, tx_byte}, 64'h3FFF);
      end else begin
        e_mon = sb_q.pop_front();
        check_val("tx_byte", tx_byte, e_mon.b);
        check_val("byte_index", byte_index, e_mon.idx);
      end
      if (stall_en && byte_index == 6'd5) check_val("stall_gap", cyc - done_cyc, 4);
      if (abort_en && byte_index == 6'd5) abort_cyc = cyc;
      else resp_cnt = 10;
      last_idx = byte_index;
    end
    if (done) done_count++;
    if (error) begin
      err_count++;
      err_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_start(input logic [255:0] h, input logic [31:0] n);
    @(negedge clk);
    best_hash       = h;
    best_hash_nonce = n;
    push_frame(h, n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
    check_val("lat_tx_dv", tx_dv, 1);
    check_val("lat_sync", tx_byte, c_SYNC);
    check_val("lat_busy", busy, 1);
  endtask

  task automatic wait_end(input int max);
    int d0, e0, k;
    d0 = done_count;
    e0 = err_count;
    k  = 0;
    while (done_count == d0 && err_count == e0 && k < max) begin
      @(negedge clk);
      k++;
    end
    #2;
    check_val("frame_end_seen", (done_count != d0) || (err_count != e0), 1);
  endtask

  task automatic wait_idx(input logic [5:0] idx);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      #2;
      k++;
    end while (!(tx_dv && byte_index == idx) && k < 2000);
    check_val("reach_index", byte_index, idx);
  endtask

  task automatic frame_checks(input int dv0, input int d0, input int e0,
                              input int exp_dv, input int exp_d, input int exp_e);
    check_val("strobes", dv_count - dv0, exp_dv);
    check_val("done_pulses", done_count - d0, exp_d);
    check_val("error_pulses", err_count - e0, exp_e);
    check_val("busy_after", busy, 0);
    check_val("index_after", byte_index, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] h;
    logic [31:0]  n;
    int dv0, d0, e0;

    rst_i = 1'b0; start = 1'b0; best_hash = '0; best_hash_nonce = '0;
    tx_active = 1'b0; tx_done = 1'b0;
    tick(3);
    #2;
    check_val("rst_tx_dv", tx_dv, 0);
    check_val("rst_tx_byte", tx_byte, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_error", error, 0);
    check_val("rst_index", byte_index, 0);
    @(negedge clk);
    rst_i = 1'b1;
    tick(2);

    // Counting-pattern hash: byte k from the MSB end holds k+1.
    for (int k = 0; k < 32; k++) h[255 - 8*k -: 8] = 8'(k + 1);
    dv0 = dv_count; d0 = done_count; e0 = err_count;
    send_start(h, 32'hDEADBEEF);
    wait_end(2000);
    tick(3); #2;
    frame_checks(dv0, d0, e0, 38, 1, 0);
    check_val("sb_empty_a", sb_q.size(), 0);

    // All-zero payload: checksum must be zero too.
    dv0 = dv_count; d0 = done_count; e0 = err_count;
    send_start('0, '0);
    wait_end(2000);
    tick(3); #2;
    frame_checks(dv0, d0, e0, 38, 1, 0);

    // Second start and input changes mid-frame must not disturb the frame.
    h = {8{$urandom}};
    n = $urandom;
    dv0 = dv_count; d0 = done_count; e0 = err_count;
    send_start(h, n);
    wait_idx(6'd10);
    @(negedge clk);
    start = 1'b1; best_hash = ~h; best_hash_nonce = ~n;
    @(negedge clk);
    start = 1'b0; best_hash = {8{$urandom}};
    wait_end(2000);
    tick(20); #2;
    frame_checks(dv0, d0, e0, 38, 1, 0);
    check_val("sb_empty_c", sb_q.size(), 0);

    // Transmitter busy for three cycles at the SEND of byte 5.
    stall_en = 1'b1;
    dv0 = dv_count; d0 = done_count; e0 = err_count;
    send_start({8{$urandom}}, $urandom);
    wait_end(2000);
    tick(3); #2;
    stall_en = 1'b0;
    frame_checks(dv0, d0, e0, 38, 1, 0);

    // No tx_done after byte 5: timeout abort 50 cycles into WAIT.
    abort_en = 1'b1;
    dv0 = dv_count; d0 = done_count; e0 = err_count;
    send_start({8{$urandom}}, $urandom);
    wait_end(2000);
    check_val("abort_delay", err_cyc - abort_cyc, 51);
    tick(3); #2;
    frame_checks(dv0, d0, e0, 6, 0, 1);
    abort_en = 1'b0;
    sb_q.delete();

    // Reset in the middle of byte 20, then an immediate new frame.
    send_start({8{$urandom}}, $urandom);
    wait_idx(6'd20);
    rst_i = 1'b0;
    #1;
    check_val("midrst_tx_dv", tx_dv, 0);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_index", byte_index, 0);
    check_val("midrst_tx_byte", tx_byte, 0);
    resp_cnt = 0; act_cnt = 0;
    sb_q.delete();
    d0 = done_count; e0 = err_count;
    tick(4);
    @(negedge clk);
    rst_i = 1'b1;
    best_hash = '0; best_hash_nonce = '0;
    push_frame('0, '0);
    start = 1'b1;
    dv0 = dv_count;
    @(negedge clk);
    start = 1'b0;
    #2;
    check_val("post_rst_dv", tx_dv, 1);
    check_val("post_rst_sync", tx_byte, c_SYNC);
    check_val("post_rst_index", byte_index, 0);
    wait_end(2000);
    tick(3); #2;
    frame_checks(dv0, d0, e0, 38, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/result_sender.md
RESULT_SENDER -- requirements
Module: result_sender

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-002 Parameter TIMEOUT_CYCLES, default 32'd100_000: maximum cycles to wait for tx_done per byte.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to transmit one result frame.
REQ-006 best_hash  input  256  lowest hash from the hash core.
REQ-007 best_hash_nonce  input  32  nonce belonging to best_hash.
REQ-008 tx_active  input  1  UART transmitter busy flag.
REQ-009 tx_done  input  1  UART transmitter single-cycle byte-complete strobe.
REQ-010 tx_dv  output  1  single-cycle byte-valid strobe to the UART transmitter.
REQ-011 tx_byte  output  8  byte presented to the UART transmitter.
REQ-012 busy  output  1  high from frame acceptance until return to IDLE.
REQ-013 done  output  1  single-cycle pulse after the last byte completes.
REQ-014 error  output  1  single-cycle pulse on per-byte timeout abort.
REQ-015 byte_index  output  6  index of the byte currently in flight, 0..37.

Function
REQ-016 Frame is 38 bytes: index 0 = SYNC_BYTE; 1..32 = best_hash, least significant byte first (index 1 = hash[7:0]); 33..36 = nonce, least significant byte first; 37 = XOR of bytes 1..36.
REQ-017 The states are IDLE, SEND, WAIT, DONE and ABORT.
REQ-018 IDLE: when start=1, latch best_hash and best_hash_nonce into internal snapshot registers, clear the checksum, set byte_index=0, and go to SEND.
REQ-019 In every state except IDLE, start is ignored; later changes on best_hash/best_hash_nonce do not affect a frame in progress.
REQ-020 SEND lasts exactly one cycle: tx_dv=1, tx_byte = frame byte at byte_index, XOR the byte into the checksum (indices 1..36 only), clear the timeout counter, go to WAIT.
REQ-021 tx_byte holds its value from SEND until the next SEND or until return to IDLE.
REQ-022 WAIT: tx_dv=0; a tx_done seen in the same cycle as SEND is ignored; tx_done in WAIT with byte_index<37 increments byte_index and goes to SEND.
REQ-023 WAIT with tx_done and byte_index=37 goes to DONE.
REQ-024 WAIT: the timeout counter increments every cycle without tx_done; reaching TIMEOUT_CYCLES goes to ABORT.
REQ-025 DONE: done=1 for one cycle, then IDLE. ABORT: error=1 for one cycle, then IDLE; in both, byte_index returns to 0.
REQ-026 busy=1 in SEND, WAIT, DONE and ABORT; busy=0 only in IDLE.
REQ-027 Latency: start at cycle N gives tx_dv=1 with tx_byte=SYNC_BYTE at cycle N+1.
REQ-028 tx_active is used only as a guard: in SEND, if tx_active=1, stay in SEND with tx_dv=0 until tx_active=0, then strobe.
REQ-029 Minimum frame time is 38 SEND cycles + 38 WAIT cycles + 1 DONE cycle.

Reset
REQ-030 While rst_i=0, independent of clk: state=IDLE, tx_dv=0, tx_byte=8'h00, busy=0, done=0, error=0, byte_index=0, and checksum, timeout counter and snapshot registers cleared.
REQ-031 Reset asserted mid-frame drops tx_dv within the same cycle, and no done or error pulse follows.
REQ-032 After rst_i deasserts, the block accepts start on the first clk edge.

Verification
REQ-033 best_hash=256'h0102...1F20 (byte k = k+1, MSB first), nonce=32'hDEADBEEF, start, tx_done 10 cycles after each tx_dv -> 38 strobes: A5, 20, 1F, ..., 01, EF, BE, AD, DE, checksum; single done pulse; busy low afterwards.
REQ-034 best_hash=0, nonce=0 -> bytes 1..37 all 8'h00; checksum 8'h00.
REQ-035 TIMEOUT_CYCLES=50, no tx_done after byte index 5 -> error pulses exactly 50 cycles after WAIT entry; no done; byte_index=0; busy=0.
REQ-036 Second start while busy at byte 10, plus best_hash changed mid-frame -> exactly one frame of 38 bytes with the original snapshot.
REQ-037 rst_i low at byte 20 -> tx_dv=0 immediately; after release, a new start sends SYNC_BYTE at index 0.
REQ-038 tx_active=1 at the SEND cycle for 3 cycles -> tx_dv held low and then strobed once on the cycle tx_active falls; byte order unchanged.
